// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the runtime baud detector.
// The calibration character is 0x55, which gives evenly spaced falling edges.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    IDLE_WAIT,
    ARMED,
    MEASURE,
    CHECK,
    DRAIN,
    PASS,
    FAIL
  } ab_state_e;

  localparam logic [7:0] CalChar      = 8'h55;
  localparam int         CalBitTimes  = 8;
  localparam int         CalIntervals = CalBitTimes / 2;

  // Divide by 2^shift, rounding half up.
  function automatic logic [31:0] round_prescale(input logic [31:0] t, input int shift);
    return (t + (32'd1 << (shift - 1))) >> shift;
  endfunction

endpackage

// File: rtl/uart_autobaud_if.sv
// Pin-side and UART-side signals of the baud detector.
// The board or bench drives through master; the detector uses slave.
interface uart_autobaud_if;
  logic        rx_i;
  logic        recal_i;
  logic        rx_o;
  logic [15:0] prescale_o;
  logic        locked_o;
  logic        error_o;

  modport master (
    output rx_i, recal_i,
    input  rx_o, prescale_o, locked_o, error_o
  );

  modport slave (
    input  rx_i, recal_i,
    output rx_o, prescale_o, locked_o, error_o
  );
endinterface

// File: rtl/uart_autobaud_sync_ff.sv
// Multi-flop synchroniser for asynchronous inputs.
// Stage 0 samples the pin; the last stage is the output.
module sync_ff #(
  parameter int               Stages   = 2,
  parameter int               Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      stage_q <= {Stages{ResetVal}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/uart_autobaud.sv
// Runtime baud detector: measures a 0x55 calibration character and drives the UART prescale.
// The calibration character is hidden from the UART; later traffic passes through.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int          SyncStages      = 2,
  parameter int          CountWidth      = 20,
  parameter int          OversampleLog2  = 3,
  parameter int          IdleCycles      = 1024,
  parameter logic [15:0] DefaultPrescale = 16'd19
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  uart_autobaud_if.slave bus
);

  localparam int                    IdleW         = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
  localparam logic [IdleW-1:0]      IdleLast      = IdleW'(IdleCycles - 1);
  localparam logic [CountWidth-1:0] CntMax        = '1;
  localparam int                    PrescaleShift = OversampleLog2 + $clog2(CalBitTimes);

  logic                  rx_s;
  logic                  rx_s_q, rx_s_d;
  ab_state_e             state_q, state_d;
  logic [IdleW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [CountWidth-1:0] last_cnt_q, last_cnt_d;
  logic [CountWidth-1:0] i1_q, i1_d;
  logic [CountWidth-1:0] t_q, t_d;
  logic [1:0]            edge_cnt_q, edge_cnt_d;
  logic [15:0]           prescale_q, prescale_d;
  logic                  locked_q, locked_d;

  logic                  fall, rise;
  logic [CountWidth-1:0] interval, deviation;
  logic [31:0]           p_full;

  sync_ff #(
    .Stages  (SyncStages),
    .Width   (1),
    .ResetVal(1'b1)
  ) u_rx_sync (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .d_i     (bus.rx_i),
    .q_o     (rx_s)
  );

  assign rx_s_d    = rx_s;
  assign fall      = rx_s_q & ~rx_s;
  assign rise      = ~rx_s_q & rx_s;
  assign interval  = cnt_q - last_cnt_q;
  assign deviation = (interval >= i1_q) ? (interval - i1_q) : (i1_q - interval);
  assign p_full    = round_prescale(32'(t_q), PrescaleShift);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    cnt_d      = cnt_q;
    last_cnt_d = last_cnt_q;
    i1_d       = i1_q;
    t_d        = t_q;
    edge_cnt_d = edge_cnt_q;
    prescale_d = prescale_q;
    locked_d   = locked_q;

    unique case (state_q)
      IDLE_WAIT: begin
        if (!rx_s) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleLast) begin
          idle_cnt_d = '0;
          state_d    = ARMED;
        end else begin
          idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
      end
      ARMED: begin
        if (fall) begin
          state_d    = MEASURE;
          cnt_d      = CountWidth'(1);
          last_cnt_d = '0;
          edge_cnt_d = '0;
        end
      end
      MEASURE: begin
        // A stuck line or a character with too few edges ends at the counter ceiling.
        if (cnt_q == CntMax) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + CountWidth'(1);
          if (fall) begin
            last_cnt_d = cnt_q;
            if (edge_cnt_q == 2'd0) begin
              i1_d       = interval;
              edge_cnt_d = 2'd1;
            end else if (deviation > (i1_q >> 2)) begin
              state_d = FAIL;
            end else if (edge_cnt_q == 2'(CalIntervals - 1)) begin
              t_d     = cnt_q;
              state_d = CHECK;
            end else begin
              edge_cnt_d = edge_cnt_q + 2'd1;
            end
          end
        end
      end
      CHECK: begin
        if (p_full == 32'd0 || p_full > 32'h0000_FFFF) begin
          state_d = FAIL;
        end else begin
          prescale_d = p_full[15:0];
          locked_d   = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (rise) state_d = PASS;
      end
      PASS: begin
        state_d = PASS;
      end
      FAIL: begin
        locked_d   = 1'b0;
        idle_cnt_d = '0;
        state_d    = IDLE_WAIT;
      end
      default: begin
        state_d = IDLE_WAIT;
      end
    endcase

    // Recalibration wins over any edge or completion seen in the same cycle.
    if (bus.recal_i) begin
      state_d    = IDLE_WAIT;
      locked_d   = 1'b0;
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rx_s_q     <= 1'b1;
      state_q    <= IDLE_WAIT;
      idle_cnt_q <= '0;
      cnt_q      <= '0;
      last_cnt_q <= '0;
      i1_q       <= '0;
      t_q        <= '0;
      edge_cnt_q <= '0;
      prescale_q <= DefaultPrescale;
      locked_q   <= 1'b0;
    end else begin
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      cnt_q      <= cnt_d;
      last_cnt_q <= last_cnt_d;
      i1_q       <= i1_d;
      t_q        <= t_d;
      edge_cnt_q <= edge_cnt_d;
      prescale_q <= prescale_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.rx_o       = (state_q == PASS) ? rx_s : 1'b1;
  assign bus.prescale_o = prescale_q;
  assign bus.locked_o   = locked_q;
  assign bus.error_o    = (state_q == FAIL);

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: a table of calibration frames plus hand-written
// sequences for pass-through, recalibration, timeout and mid-measurement reset.
module tb_uart_autobaud;
  import uart_autobaud_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  uart_autobaud_if bus ();

  uart_autobaud #(
    .SyncStages     (2),
    .CountWidth     (14),
    .OversampleLog2 (3),
    .IdleCycles     (64),
    .DefaultPrescale(16'd19)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    int          bt;
    int          mod_pos;
    int          mod_len;
    logic        exp_err;
    logic        exp_lock;
    logic [15:0] exp_pre;
  } vec_t;

  vec_t vecs [8];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   err_cyc = 0;
  int   hi_viol = 0;
  int   pass_mis = 0;
  int   pass_low = 0;
  int   lock_rise_cyc = -1;
  logic chk_hi = 1'b0;
  logic chk_pass = 1'b0;
  logic locked_prev = 1'b0;
  logic pin_h1, pin_h2;
  int   e0, h0, m0, l0, f5, wait_n;

  always @(posedge clk) cyc <= cyc + 1;

  // Observers sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.error_o === 1'b1) err_cyc <= err_cyc + 1;
    if (chk_hi && bus.rx_o !== 1'b1) hi_viol <= hi_viol + 1;
    if (chk_pass) begin
      if (bus.rx_o !== pin_h2) pass_mis <= pass_mis + 1;
      if (bus.rx_o === 1'b0) pass_low <= pass_low + 1;
    end
    pin_h2 <= pin_h1;
    pin_h1 <= bus.rx_i;
    if (bus.locked_o === 1'b1 && !locked_prev) lock_rise_cyc <= cyc;
    locked_prev <= bus.locked_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive(input logic level, input int len);
    bus.rx_i = level;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch, input int bt, input int mod_pos,
                      input int mod_len, input int npos);
    logic [9:0] frame;
    frame = {1'b1, ch, 1'b0};
    for (int p = 0; p < npos; p++) drive(frame[p], (p == mod_pos) ? mod_len : bt);
  endtask

  task automatic pulse_recal();
    bus.recal_i = 1'b1;
    @(posedge clk);
    #1;
    bus.recal_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_prescale"}, 32'(bus.prescale_o), 32'd19);
    check({tag, "_locked"},   32'(bus.locked_o),   32'd0);
    check({tag, "_rx_o"},     32'(bus.rx_o),       32'd1);
    check({tag, "_error"},    32'(bus.error_o),    32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Intervals of 370/400 are inside the 80-cycle window around 320; 401 and 239 are not.
    vecs[0] = '{CalChar, 156, -1,   0, 1'b0, 1'b1, 16'd20};
    vecs[1] = '{CalChar, 160,  7, 241, 1'b1, 1'b0, 16'd20};
    vecs[2] = '{CalChar, 160,  7, 210, 1'b0, 1'b1, 16'd21};
    vecs[3] = '{CalChar, 160,  7, 240, 1'b0, 1'b1, 16'd21};
    vecs[4] = '{CalChar, 160,  7,  79, 1'b1, 1'b0, 16'd21};
    vecs[5] = '{CalChar, 160,  7,  80, 1'b0, 1'b1, 16'd19};
    vecs[6] = '{CalChar, 120, -1,   0, 1'b0, 1'b1, 16'd15};
    vecs[7] = '{CalChar,  80, -1,   0, 1'b0, 1'b1, 16'd10};

    reset_n     = 1'b0;
    bus.rx_i    = 1'b1;
    bus.recal_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;

    // First lock at 160 clk/bit, then a data byte through the pass-through path.
    idle(100);
    h0 = hi_viol;
    chk_hi = 1'b1;
    send(CalChar, 160, -1, 0, 8);
    check("locked_before_5th_fall", 32'(bus.locked_o), 32'd0);
    f5 = cyc;
    drive(1'b0, 160);
    drive(1'b1, 160);
    chk_hi = 1'b0;
    check("lock_locked", 32'(bus.locked_o), 32'd1);
    check("lock_prescale", 32'(bus.prescale_o), 32'd20);
    check("lock_after_5th_fall", 32'((lock_rise_cyc > f5) && (lock_rise_cyc <= f5 + 8)), 32'd1);
    check("lock_cal_hidden", 32'(hi_viol - h0), 32'd0);
    m0 = pass_mis;
    l0 = pass_low;
    chk_pass = 1'b1;
    send(8'hA3, 20, -1, 0, 10);
    idle(5);
    chk_pass = 1'b0;
    check("pass_a3_mismatch", 32'(pass_mis - m0), 32'd0);
    check("pass_a3_low_cycles", 32'(pass_low - l0), 32'd100);

    for (int i = 0; i < 8; i++) begin
      pulse_recal();
      idle(100);
      e0 = err_cyc;
      h0 = hi_viol;
      chk_hi = 1'b1;
      send(vecs[i].ch, vecs[i].bt, vecs[i].mod_pos, vecs[i].mod_len, 10);
      idle(10);
      chk_hi = 1'b0;
      check($sformatf("v%0d_err", i), 32'(err_cyc - e0), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_locked", i), 32'(bus.locked_o), 32'(vecs[i].exp_lock));
      check($sformatf("v%0d_prescale", i), 32'(bus.prescale_o), 32'(vecs[i].exp_pre));
      check($sformatf("v%0d_hidden", i), 32'(hi_viol - h0), 32'd0);
    end

    // Wrong character: a single falling edge, so the counter must run out.
    pulse_recal();
    idle(100);
    e0 = err_cyc;
    h0 = hi_viol;
    chk_hi = 1'b1;
    send(8'h00, 160, -1, 0, 10);
    wait_n = 0;
    while (err_cyc == e0 && wait_n < 17000) begin
      @(posedge clk);
      wait_n++;
    end
    #1;
    idle(5);
    chk_hi = 1'b0;
    check("timeout_err_pulse", 32'(err_cyc - e0), 32'd1);
    check("timeout_locked", 32'(bus.locked_o), 32'd0);
    check("timeout_prescale", 32'(bus.prescale_o), 32'd10);
    check("timeout_hidden", 32'(hi_viol - h0), 32'd0);

    // Recalibration while passing a byte through, then relock at 80 clk/bit.
    pulse_recal();
    idle(100);
    send(CalChar, 160, -1, 0, 10);
    idle(10);
    check("recal_pre_prescale", 32'(bus.prescale_o), 32'd20);
    drive(1'b0, 6);
    check("recal_byte_passing", 32'(bus.rx_o), 32'd0);
    pulse_recal();
    check("recal_cut_rx_o", 32'(bus.rx_o), 32'd1);
    check("recal_locked_drop", 32'(bus.locked_o), 32'd0);
    check("recal_prescale_hold", 32'(bus.prescale_o), 32'd20);
    drive(1'b0, 100);
    idle(100);
    send(CalChar, 80, -1, 0, 8);
    check("relock_prescale_before", 32'(bus.prescale_o), 32'd20);
    check("relock_locked_before", 32'(bus.locked_o), 32'd0);
    drive(1'b0, 80);
    drive(1'b1, 80);
    idle(10);
    check("relock_prescale", 32'(bus.prescale_o), 32'd10);
    check("relock_locked", 32'(bus.locked_o), 32'd1);

    // Recal lands in the same cycle as the fifth falling edge.
    pulse_recal();
    idle(100);
    e0 = err_cyc;
    send(CalChar, 160, -1, 0, 8);
    bus.rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.recal_i = 1'b1;
    @(posedge clk);
    #1;
    bus.recal_i = 1'b0;
    drive(1'b0, 157);
    drive(1'b1, 160);
    idle(10);
    check("prio_locked", 32'(bus.locked_o), 32'd0);
    check("prio_prescale", 32'(bus.prescale_o), 32'd10);
    check("prio_err", 32'(err_cyc - e0), 32'd0);

    // Reset after two falling edges of a calibration character.
    idle(100);
    send(CalChar, 160, -1, 0, 2);
    drive(1'b0, 20);
    reset_n  = 1'b0;
    bus.rx_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("midreset");
    reset_n = 1'b1;
    idle(100);
    send(CalChar, 120, -1, 0, 10);
    idle(10);
    check("after_reset_locked", 32'(bus.locked_o), 32'd1);
    check("after_reset_prescale", 32'(bus.prescale_o), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic idle(input int n);
    drive(1'b1, n);
  endtask

endmodule
